// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer read pipeline; pins lag the counters by 2 clocks.
// Define VGA_TEST_PATTERN_EN to add pattern_sel and an 8-bar colour test pattern.
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   output logic        rd_en,
   output logic [10:0] rd_x,
   output logic [10:0] rd_y,
   input  logic [11:0] rd_data,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        vblank,
   output logic        frame_start
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [0:0]  state;
   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        running;
   logic        visible;
   logic        hs0;
   logic        vs0;
   logic        vis_d1;
   logic        hs_d1;
   logic        vs_d1;
   logic [11:0] pix;

   // en is only looked at in IDLE and on the very last clock of a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (state == IDLE) begin
         h_cnt <= '0;
         v_cnt <= '0;
         if (en) state <= RUN;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         if (v_cnt == V_LAST) begin
            v_cnt <= '0;
            if (!en) state <= IDLE;
         end else begin
            v_cnt <= v_cnt + 11'd1;
         end
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   always_comb begin
      running     = (state == RUN);
      visible     = running && (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs0         = !(running && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs0         = !(running && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
      vblank      = !running || (v_cnt >= V_VIS);
      frame_start = running && (h_cnt == 11'd0) && (v_cnt == 11'd0);
      rd_x        = visible ? h_cnt : 11'd0;
      rd_y        = visible ? v_cnt : 11'd0;
   end

`ifdef VGA_TEST_PATTERN_EN
   logic       pat_d1;
   logic [2:0] bar_d1;

   assign rd_en = visible && !pattern_sel;

   // bar index travels with the pixel so bars share the memory path's latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_d1 <= 1'b0;
         bar_d1 <= 3'd0;
      end else begin
         pat_d1 <= pattern_sel;
         bar_d1 <= 3'(h_cnt / 11'(H_ACTIVE / 8));
      end
   end

   assign pix = pat_d1 ? {bar_d1[2] ? 4'hF : 4'h0,
                          bar_d1[1] ? 4'hF : 4'h0,
                          bar_d1[0] ? 4'hF : 4'h0} : rd_data;
`else
   assign rd_en = visible;
   assign pix   = rd_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vis_d1 <= 1'b0;
         hs_d1  <= 1'b1;
         vs_d1  <= 1'b1;
      end else begin
         vis_d1 <= visible;
         hs_d1  <= hs0;
         vs_d1  <= vs0;
      end
   end

   // blanked pixels are forced to black regardless of what memory returned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red   <= 4'h0;
         green <= 4'h0;
         blue  <= 4'h0;
         de    <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         red   <= vis_d1 ? pix[3:0]  : 4'h0;
         green <= vis_d1 ? pix[7:4]  : 4'h0;
         blue  <= vis_d1 ? pix[11:8] : 4'h0;
         de    <= vis_d1;
         hsync <= hs_d1;
         vsync <= vs_d1;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout, run with a shrunken screen geometry so whole frames fit in a short run.
// The reference model tracks a single linear frame position and derives every output from it.
module tb_vga_scanout;

   localparam int HA = 64;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int VA = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        pattern_sel = 1'b0;
   logic        rd_en;
   logic [10:0] rd_x;
   logic [10:0] rd_y;
   logic [11:0] rd_data = 12'h000;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic        vblank;
   logic        frame_start;

   typedef struct packed {
      logic        rd_en;
      logic [10:0] rd_x;
      logic [10:0] rd_y;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        hs;
      logic        vs;
      logic        de;
      logic        vb;
      logic        fs;
   } outs_t;

   typedef struct {
      int   x;
      int   y;
      logic pat;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } probe_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // model: -1 means idle, otherwise clocks since the start of the current frame
   int   pos = -1;
   int   d1 = -1;
   int   d2 = -1;
   logic pd1 = 1'b0;
   logic pd2 = 1'b0;

   int fs_count = 0;
   int fs_cyc = 0;
   int fs_seen = 0;
   int fs_period = -1;
   int hs_run = 0;
   int hs_last = -1;
   int hs_first = -1;
   int vs_run = 0;
   int vs_last = -1;
   int de_run = 0;
   int de_runs = 0;
   int de_bad = 0;

   probe_t probes[$];

   always #5 clk = ~clk;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .rd_en(rd_en),
      .rd_x(rd_x),
      .rd_y(rd_y),
      .rd_data(rd_data),
      .red(red),
      .green(green),
      .blue(blue),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .vblank(vblank),
      .frame_start(frame_start)
   );

   // synchronous framebuffer whose contents are a fixed function of the address
   always @(posedge clk) begin
      if (rd_en) rd_data <= {rd_x[3:0], rd_y[3:0], rd_x[7:4]};
   end

   function automatic int nextPos(int p, logic e);
      if (p < 0 || p == FRAME - 1) return e ? 0 : -1;
      return p + 1;
   endfunction

   function automatic outs_t modelOut(int p0, logic pat0, int p2, logic pat2);
      outs_t e;
      int x0, y0, x2, y2, bar;
      logic vis0, vis2;
      e = '0;
      x0 = (p0 < 0) ? 0 : p0 % HT;
      y0 = (p0 < 0) ? 0 : p0 / HT;
      x2 = (p2 < 0) ? 0 : p2 % HT;
      y2 = (p2 < 0) ? 0 : p2 / HT;
      vis0 = (p0 >= 0) && (x0 < HA) && (y0 < VA);
      vis2 = (p2 >= 0) && (x2 < HA) && (y2 < VA);
      e.rd_en = vis0 && !pat0;
      e.rd_x  = vis0 ? 11'(x0) : 11'd0;
      e.rd_y  = vis0 ? 11'(y0) : 11'd0;
      e.vb    = (p0 < 0) || (y0 >= VA);
      e.fs    = (p0 == 0);
      e.hs    = !((p2 >= 0) && (x2 >= HA + HF) && (x2 < HA + HF + HS));
      e.vs    = !((p2 >= 0) && (y2 >= VA + VF) && (y2 < VA + VF + VS));
      e.de    = vis2;
      if (vis2 && pat2) begin
         bar = x2 / (HA / 8);
         e.r = (bar % 2 == 1) ? 4'hF : 4'h0;
         e.g = ((bar / 2) % 2 == 1) ? 4'hF : 4'h0;
         e.b = ((bar / 4) % 2 == 1) ? 4'hF : 4'h0;
      end else if (vis2) begin
         e.r = 4'((x2 / 16) % 16);
         e.g = 4'(y2 % 16);
         e.b = 4'(x2 % 16);
      end
      return e;
   endfunction

   task automatic checkVal(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic checkOutput(string name);
      outs_t act, exp;
      act = {rd_en, rd_x, rd_y, red, green, blue, hsync, vsync, de, vblank, frame_start};
      exp = modelOut(pos, pattern_sel, d2, pd2);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h (pos %0d)", name, cyc, act, exp, pos);
      end
   endtask

   task automatic monitor();
      if (frame_start) begin
         if (fs_seen != 0) fs_period = cyc - fs_cyc;
         fs_cyc = cyc;
         fs_seen = 1;
         fs_count++;
      end
      if (!hsync) begin
         if (hs_first < 0 && fs_seen != 0) hs_first = cyc - fs_cyc;
         hs_run++;
      end else if (hs_run > 0) begin
         hs_last = hs_run;
         hs_run = 0;
      end
      if (!vsync) vs_run++;
      else if (vs_run > 0) begin
         vs_last = vs_run;
         vs_run = 0;
      end
      if (de) de_run++;
      else if (de_run > 0) begin
         de_runs++;
         if (de_run != HA) de_bad++;
         de_run = 0;
      end
   endtask

   // one clock: advance the model on the edge, then compare just after it
   task automatic applyStimulus();
      @(posedge clk);
      cyc++;
      d2 = d1;
      pd2 = pd1;
      d1 = pos;
      pd1 = pattern_sel;
      pos = rst_n ? nextPos(pos, en) : -1;
      #1;
      checkOutput("cycle");
      monitor();
   endtask

   task automatic waitPos(int target, string name);
      int n;
      n = 0;
      while (pos != target && n < 3 * FRAME) begin
         applyStimulus();
         n++;
      end
      checkVal({name, "_reached"}, pos, target);
   endtask

   initial begin
      int base, n;
      probes.push_back('{37, 5, 1'b0, 4'h2, 4'h5, 4'h5});
      probes.push_back('{0, 0, 1'b0, 4'h0, 4'h0, 4'h0});
      probes.push_back('{63, 11, 1'b0, 4'h3, 4'hB, 4'hF});
      probes.push_back('{16, 1, 1'b0, 4'h1, 4'h1, 4'h0});
      probes.push_back('{47, 10, 1'b0, 4'h2, 4'hA, 4'hF});
`ifdef VGA_TEST_PATTERN_EN
      probes.push_back('{3, 2, 1'b1, 4'h0, 4'h0, 4'h0});
      probes.push_back('{9, 4, 1'b1, 4'hF, 4'h0, 4'h0});
      probes.push_back('{45, 3, 1'b1, 4'hF, 4'h0, 4'hF});
      probes.push_back('{60, 6, 1'b1, 4'hF, 4'hF, 4'hF});
`endif

      for (int i = 0; i < 5; i++) applyStimulus();
      checkVal("reset_hsync", hsync, 1);
      checkVal("reset_vsync", vsync, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) applyStimulus();
      checkVal("idle_frame_start_count", fs_count, 0);
      checkVal("idle_vblank", vblank, 1);
      checkVal("idle_de_runs", de_runs, 0);

      en = 1'b1;
      for (int i = 0; i < 2 * FRAME + 20; i++) applyStimulus();
      checkVal("frame_start_period", fs_period, FRAME);
      checkVal("hsync_offset", hs_first, HA + HF + 2);
      checkVal("hsync_width", hs_last, HS);
      checkVal("vsync_width", vs_last, VS * HT);
      checkVal("de_lines", de_runs, 2 * VA);
      checkVal("de_bad_widths", de_bad, 0);

      foreach (probes[k]) begin
         pattern_sel = probes[k].pat;
         n = 0;
         while (!(d2 == probes[k].y * HT + probes[k].x && pd2 == probes[k].pat) && n < 3 * FRAME) begin
            applyStimulus();
            n++;
         end
         checkVal("probe_reached", n < 3 * FRAME ? 1 : 0, 1);
         checkVal("probe_red", red, probes[k].r);
         checkVal("probe_green", green, probes[k].g);
         checkVal("probe_blue", blue, probes[k].b);
      end
      pattern_sel = 1'b0;

      for (int i = 0; i < 6 * FRAME; i++) begin
         en = ($urandom_range(0, 3) != 0);
`ifdef VGA_TEST_PATTERN_EN
         if ($urandom_range(0, 63) == 0) pattern_sel = ~pattern_sel;
`endif
         applyStimulus();
      end
      pattern_sel = 1'b0;

      // drop en mid-frame: the frame must still run to its last line
      en = 1'b1;
      waitPos(7 * HT, "drop_point");
      en = 1'b0;
      base = de_runs;
      n = 0;
      while (pos != -1 && n < 2 * FRAME) begin
         applyStimulus();
         n++;
      end
      for (int i = 0; i < 3; i++) applyStimulus();
      checkVal("drop_lines_completed", de_runs - base, VA - 7);
      checkVal("drop_idle_hsync", hsync, 1);
      checkVal("drop_idle_vblank", vblank, 1);
      base = fs_count;
      for (int i = 0; i < 50; i++) applyStimulus();
      checkVal("drop_no_restart", fs_count - base, 0);
      en = 1'b1;
      applyStimulus();
      checkVal("reraise_frame_start", frame_start, 1);

      // asynchronous reset in the middle of an hsync pulse
      waitPos(HA + HF + 3, "hsync_mid");
      checkVal("hsync_low_before_reset", hsync, 0);
      rst_n = 1'b0;
      #1;
      pos = -1;
      d1 = -1;
      d2 = -1;
      pd1 = 1'b0;
      pd2 = 1'b0;
      checkOutput("async_reset");
      checkVal("async_hsync", hsync, 1);
      checkVal("async_de", de, 0);
      for (int i = 0; i < 3; i++) applyStimulus();
      rst_n = 1'b1;
      applyStimulus();
      checkVal("restart_frame_start", frame_start, 1);
      checkVal("restart_rd_x", rd_x, 0);
      for (int i = 0; i < HT * 3; i++) applyStimulus();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
